// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: edge-captures requests, injects bubble/push words into decode, then redirects fetch to the IVT.
// Optional macro IRQ_ROTATE_PRIORITY_EN selects round-robin grant priority instead of fixed (bit 0 highest).
module interrupt_sequencer #(
  parameter logic [15:0] BUBBLE_INSTR     = 16'h07F8,
  parameter logic [15:0] PUSH_PC_INSTR    = 16'hF480,
  parameter logic [15:0] PUSH_FLAGS_INSTR = 16'hF4C0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  irqReq,
  input  logic [2:0]  functionBits,
  input  logic        stallIn,
  input  logic        rtiDone,
  output logic        fetchHold,
  output logic        injectValid,
  output logic [15:0] injectInstruction,
  output logic        fetchRedirect,
  output logic [1:0]  vectorIndex,
  output logic [3:0]  irqAck,
  output logic        inService
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IMM, S_BUBBLE, S_PUSH_PC, S_PUSH_FLAGS, S_REDIRECT, S_IN_SERVICE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_pending;
  logic [3:0]  r_prev;
  logic        r_live;
  logic [1:0]  r_grant;
  logic [3:0]  w_rise;
  logic [3:0]  w_ack;
  logic [3:0]  w_clr;
  logic [1:0]  w_pick;
`ifdef IRQ_ROTATE_PRIORITY_EN
  logic [1:0]  r_last;
  logic [1:0]  w_cand;
`endif

  // r_live masks the first sample after reset so a line held high across reset release is not an edge.
  assign w_rise = irqReq & ~r_prev & {4{r_live}};
  assign w_ack  = (r_state == S_REDIRECT) ? (4'b0001 << r_grant) : 4'b0000;
  // A stalled acknowledge stays asserted; the pending bit clears once, when the stall lets it retire.
  assign w_clr  = stallIn ? 4'b0000 : w_ack;

`ifdef IRQ_ROTATE_PRIORITY_EN
  always_comb begin
    w_pick = 2'd0;
    w_cand = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      w_cand = r_last + 2'(i) + 2'd1;
      if (r_pending[w_cand]) w_pick = w_cand;
    end
  end
`else
  always_comb begin
    w_pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_pending[i]) w_pick = 2'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pending <= 4'b0000;
      r_prev    <= 4'b0000;
      r_live    <= 1'b0;
      r_grant   <= 2'd0;
`ifdef IRQ_ROTATE_PRIORITY_EN
      r_last    <= 2'd3;
`endif
    end else begin
      r_prev    <= irqReq;
      r_live    <= 1'b1;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (!stallIn) begin
        case (r_state)
          S_IDLE: begin
            if (|r_pending) begin
              r_grant <= w_pick;
              r_state <= (functionBits == 3'b100) ? S_WAIT_IMM : S_BUBBLE;
            end
          end
          S_WAIT_IMM:   r_state <= S_BUBBLE;
          S_BUBBLE:     r_state <= S_PUSH_PC;
          S_PUSH_PC:    r_state <= S_PUSH_FLAGS;
          S_PUSH_FLAGS: r_state <= S_REDIRECT;
          S_REDIRECT: begin
            r_state <= S_IN_SERVICE;
`ifdef IRQ_ROTATE_PRIORITY_EN
            r_last  <= r_grant;
`endif
          end
          S_IN_SERVICE: if (rtiDone) r_state <= S_IDLE;
          default:      r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Moore decode: every output is a function of the state and grant registers only.
  always_comb begin
    fetchHold         = 1'b0;
    injectValid       = 1'b0;
    injectInstruction = BUBBLE_INSTR;
    fetchRedirect     = 1'b0;
    vectorIndex       = 2'd0;
    irqAck            = w_ack;
    inService         = 1'b0;
    case (r_state)
      S_WAIT_IMM: fetchHold = 1'b1;
      S_BUBBLE: begin
        fetchHold   = 1'b1;
        injectValid = 1'b1;
      end
      S_PUSH_PC: begin
        fetchHold         = 1'b1;
        injectValid       = 1'b1;
        injectInstruction = PUSH_PC_INSTR;
      end
      S_PUSH_FLAGS: begin
        fetchHold         = 1'b1;
        injectValid       = 1'b1;
        injectInstruction = PUSH_FLAGS_INSTR;
      end
      S_REDIRECT: begin
        fetchHold     = 1'b1;
        fetchRedirect = 1'b1;
        vectorIndex   = r_grant;
      end
      S_IN_SERVICE: inService = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 Parameter BUBBLE_INSTR, default 16'h07F8: no-op word injected into decode.
REQ-002 Parameter PUSH_PC_INSTR, default 16'hF480: first injected save word (push PC).
REQ-003 Parameter PUSH_FLAGS_INSTR, default 16'hF4C0: second injected save word (push flags).
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-low.
REQ-006 Port irqReq  input  4: interrupt request lines; bit 0 is highest fixed priority.
REQ-007 Port functionBits  input  3: function field of the instruction in fetch; 3'b100 marks a two-word immediate instruction.
REQ-008 Port stallIn  input  1: pipeline stall; freezes the sequencer.
REQ-009 Port rtiDone  input  1: one-cycle pulse when an RTI retires.
REQ-010 Port fetchHold  output  1: fetch must not advance PC.
REQ-011 Port injectValid  output  1: injectInstruction replaces the fetched word this cycle.
REQ-012 Port injectInstruction  output  16: word injected into decode.
REQ-013 Port fetchRedirect  output  1: one-cycle pulse telling fetch to load the IVT entry.
REQ-014 Port vectorIndex  output  2: IVT entry of the granted source; valid while fetchRedirect=1.
REQ-015 Port irqAck  output  4: one-hot, one-cycle acknowledge to the granted source.
REQ-016 Port inService  output  1: a handler is executing; no new grant.

Function
REQ-017 Each irqReq bit SHALL be edge-detected against a registered previous sample; a rising edge sets its pending bit at that clock edge.
REQ-018 A pending bit SHALL clear only in the cycle its irqAck pulses; a new edge on the same bit in that cycle SHALL re-set it (set wins).
REQ-019 States: IDLE, WAIT_IMM, BUBBLE, PUSH_PC, PUSH_FLAGS, REDIRECT, IN_SERVICE; outputs SHALL be decoded from the state register only (Moore).
REQ-020 IDLE with any pending bit and stallIn=0: grant SHALL be captured (highest priority pending) and next state WAIT_IMM if functionBits==3'b100, else BUBBLE.
REQ-021 WAIT_IMM SHALL last one cycle, fetchHold=1, injectValid=0, letting the immediate second word enter decode; then BUBBLE.
REQ-022 BUBBLE: injectValid=1, injectInstruction=BUBBLE_INSTR; then PUSH_PC.
REQ-023 PUSH_PC: injectValid=1, PUSH_PC_INSTR; then PUSH_FLAGS: injectValid=1, PUSH_FLAGS_INSTR; then REDIRECT.
REQ-024 REDIRECT: fetchRedirect=1, vectorIndex=granted index, irqAck one-hot for granted bit; then IN_SERVICE.
REQ-025 fetchHold SHALL be 1 in WAIT_IMM through REDIRECT inclusive, else 0.
REQ-026 IN_SERVICE: inService=1; on rtiDone=1 return to IDLE next cycle; requests arriving meanwhile stay pending.
REQ-027 rtiDone outside IN_SERVICE SHALL be ignored.
REQ-028 stallIn=1 SHALL hold state, grant and all outputs unchanged (except irqAck/fetchRedirect, held asserted until the stall drops and counted once); pending capture continues.
REQ-029 In non-injecting states injectInstruction SHALL equal BUBBLE_INSTR.
REQ-030 Minimum latency, IDLE to fetchRedirect, non-immediate case: 4 cycles after leaving IDLE (BUBBLE, PUSH_PC, PUSH_FLAGS, REDIRECT).

Reset
REQ-031 rst=0 at a clock edge SHALL force IDLE, clear pending, grant and previous-sample registers, regardless of current state.
REQ-032 Reset values: fetchHold=0, injectValid=0, injectInstruction=BUBBLE_INSTR, fetchRedirect=0, vectorIndex=0, irqAck=0, inService=0.
REQ-033 A line held high through reset release SHALL NOT create a pending bit until it falls and rises again.

Configuration
REQ-034 Macro IRQ_ROTATE_PRIORITY_EN defined: grant SHALL use round-robin priority starting at the bit after the last granted (bit 0 after reset).
REQ-035 Macro undefined: fixed priority, bit 0 highest; no rotation state implemented.

Verification
REQ-036 irqReq[2] edge, functionBits=000, idle -> BUBBLE, PUSH_PC, PUSH_FLAGS words on injectValid, then fetchRedirect=1, vectorIndex=2, irqAck=4'b0100.
REQ-037 irqReq[1] edge with functionBits=100 -> one cycle fetchHold=1, injectValid=0, then same sequence, vectorIndex=1.
REQ-038 Edges on bits 3 and 1 same cycle, fixed priority -> bit 1 served; after rtiDone bit 3 served; with IRQ_ROTATE_PRIORITY_EN, bits 0 and 1 pending after grant 0 -> bit 1 served next.
REQ-039 stallIn=1 for 3 cycles during PUSH_PC -> PUSH_PC_INSTR held 3 extra cycles, irqAck pulses exactly once.
REQ-040 rst=0 in PUSH_FLAGS -> next cycle all outputs at reset values, pending=0.
REQ-041 rtiDone pulse in IDLE -> no state change; irqReq held high across reset release -> no grant.
